// File: rtl/fetch_stage.sv
// Instruction-fetch stage: assembles 32-bit instructions from two halfword reads into a one-entry IF/ID buffer.
// Optional instruction-load counter enabled by defining FETCH_PERF_EN.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [15:0]       imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       instr_count
`endif
);

  typedef enum logic [2:0] {IDLE, HI, LO, CAP, FULL} fetchStateT;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  fetchStateT        state, nextState;
  logic [ADDR_W-1:0] fpc;
  logic [15:0]       hiQ, loQ;
  logic              bufFree, loadEn;

  assign bufFree = !ifid_valid || !stall;
  // A branch suppresses any load in the same edge, so old-path data never lands.
  assign loadEn  = !branch_taken &&
                   (((state == CAP) && bufFree) || ((state == FULL) && !stall));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    nextState = state;
    if (branch_taken) begin
      nextState = HI;
    end else begin
      unique case (state)
        IDLE:    nextState = HI;
        HI:      nextState = LO;
        LO:      nextState = CAP;
        CAP:     nextState = bufFree ? HI : FULL;
        FULL:    nextState = stall ? FULL : HI;
        default: nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_rd   = 1'b0;
    imem_addr = fpc;
    unique case (state)
      HI: imem_rd = 1'b1;
      LO: begin
        imem_rd   = 1'b1;
        imem_addr = fpc + ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc        <= RESET_PC & ~ONE;
      hiQ        <= '0;
      loQ        <= '0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else if (branch_taken) begin
      fpc        <= branch_target & ~ONE;
      ifid_valid <= 1'b0;
    end else begin
      if (state == LO) hiQ <= imem_data;
      // Buffer occupied at capture time: park the low half until decode drains.
      if ((state == CAP) && !bufFree) loQ <= imem_data;
      if (loadEn) begin
        ifid_instr <= {hiQ, (state == CAP) ? imem_data : loQ};
        ifid_pc    <= fpc;
        ifid_valid <= 1'b1;
        fpc        <= fpc + TWO;
      end else if (ifid_valid && !stall) begin
        ifid_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instr_count <= '0;
    else if (loadEn) instr_count <= instr_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/branch traffic checked
// against an instruction-stream scoreboard (expected PC sequence and memory contents).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;

  logic [31:0] imemAddr, imemAddr1;
  logic        imemRd, imemRd1;
  logic [15:0] imemData = '0, imemData1 = '0;
  logic [31:0] ifidInstr, ifidInstr1, ifidPc, ifidPc1;
  logic        ifidValid, ifidValid1;
`ifdef FETCH_PERF_EN
  logic [31:0] instrCount, instrCount1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .imem_addr(imemAddr), .imem_rd(imemRd), .imem_data(imemData),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .ifid_instr(ifidInstr), .ifid_pc(ifidPc), .ifid_valid(ifidValid)
`ifdef FETCH_PERF_EN
    , .instr_count(instrCount)
`endif
  );

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFE)) dut1 (
    .clk(clk), .reset(reset), .imem_addr(imemAddr1), .imem_rd(imemRd1), .imem_data(imemData1),
    .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
    .ifid_instr(ifidInstr1), .ifid_pc(ifidPc1), .ifid_valid(ifidValid1)
`ifdef FETCH_PERF_EN
    , .instr_count(instrCount1)
`endif
  );

  function automatic logic [15:0] memAt(input logic [31:0] a);
    case (a)
      32'd0:   return 16'h1234;
      32'd1:   return 16'h5678;
      32'd2:   return 16'hAAAA;
      32'd3:   return 16'h5555;
      default: return (a[15:0] * 16'h9E37) ^ a[31:16] ^ 16'h3C5A;
    endcase
  endfunction

  function automatic logic [31:0] instrAt(input logic [31:0] pc);
    return {memAt(pc), memAt(pc + 32'd1)};
  endfunction

  // Instruction memory with one-cycle read latency.
  always @(posedge clk) begin
    if (imemRd)  imemData  <= memAt(imemAddr);
    if (imemRd1) imemData1 <= memAt(imemAddr1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] expPc;
  logic [31:0] heldPc, heldInstr;
  bit          held, brPrev;
  int          consumed;

  initial begin
    #1;
    check("rst_valid", ifidValid, 0);
    check("rst_pc", ifidPc, 0);
    check("rst_instr", ifidInstr, 0);
    check("rst_rd", imemRd, 0);
    check("rst_addr", imemAddr, 0);
`ifdef FETCH_PERF_EN
    check("rst_count", instrCount, 0);
`endif
    step(); step();
    reset = 1'b1;

    // Basic fetch, and the wrapping instance
    step();
    check("t1_hi_rd", imemRd, 1);
    check("t1_hi_addr", imemAddr, 0);
    step();
    check("t1_lo_addr", imemAddr, 1);
    check("t5_lo_addr", imemAddr1, 32'hFFFF_FFFF);
    step();
    check("t1_cap_rd", imemRd, 0);
    check("t1_cap_valid", ifidValid, 0);
    step();
    check("t1_valid", ifidValid, 1);
    check("t1_instr", ifidInstr, 32'h1234_5678);
    check("t1_pc", ifidPc, 0);
    check("t1_next_addr", imemAddr, 2);
    check("t5_pc0", ifidPc1, 32'hFFFF_FFFE);
    check("t5_instr0", ifidInstr1, instrAt(32'hFFFF_FFFE));
`ifdef FETCH_PERF_EN
    check("t1_count", instrCount, 1);
`endif

    // Stall held from first valid: park in FULL
    stall = 1'b1;
    step();
    check("t2_lo_addr", imemAddr, 3);
    step();
    check("t2_cap_pc", ifidPc, 0);
    step();
    check("t2_full_rd", imemRd, 0);
    check("t2_full_pc", ifidPc, 0);
    check("t2_full_valid", ifidValid, 1);
    check("t5_pc1", ifidPc1, 32'h0);
    check("t5_instr1", ifidInstr1, 32'h1234_5678);
    step();
    check("t2_full2_rd", imemRd, 0);
    check("t2_full2_instr", ifidInstr, 32'h1234_5678);
    stall = 1'b0;
    step();
    check("t2_pc", ifidPc, 2);
    check("t2_instr", ifidInstr, 32'hAAAA_5555);
    check("t2_valid", ifidValid, 1);
    check("t2_addr", imemAddr, 4);
`ifdef FETCH_PERF_EN
    check("t2_count", instrCount, 2);
`endif

    // Branch during LO
    step();
    check("t3_lo_addr", imemAddr, 5);
    branch_taken = 1'b1;
    branch_target = 32'h41;
    step();
    branch_taken = 1'b0;
    check("t3_flush", ifidValid, 0);
    check("t3_addr", imemAddr, 32'h40);
    check("t3_rd", imemRd, 1);
    step();
    check("t3_lo", imemAddr, 32'h41);
    step();
    check("t3_cap_valid", ifidValid, 0);
    step();
    check("t3_valid", ifidValid, 1);
    check("t3_pc", ifidPc, 32'h40);
    check("t3_instr", ifidInstr, instrAt(32'h40));
    check("t3_next_addr", imemAddr, 32'h42);

    // Branch while parked in FULL with stall
    stall = 1'b1;
    step();
    check("t4_lo_addr", imemAddr, 32'h43);
    step(); step();
    check("t4_full_rd", imemRd, 0);
    check("t4_full_pc", ifidPc, 32'h40);
    branch_taken = 1'b1;
    branch_target = 32'h80;
    step();
    branch_taken = 1'b0;
    stall = 1'b0;
    check("t4_valid", ifidValid, 0);
    check("t4_rd", imemRd, 1);
    check("t4_addr", imemAddr, 32'h80);
`ifdef FETCH_PERF_EN
    check("t4_count", instrCount, 3);
`endif

    // Async reset while in CAP
    step();
    check("t6_lo_addr", imemAddr, 32'h81);
    step();
    check("t6_cap_rd", imemRd, 0);
    #2 reset = 1'b0;
    #1;
    check("t6_valid", ifidValid, 0);
    check("t6_pc", ifidPc, 0);
    check("t6_instr", ifidInstr, 0);
    check("t6_rd", imemRd, 0);
    check("t6_addr", imemAddr, 0);
`ifdef FETCH_PERF_EN
    check("t6_count", instrCount, 0);
`endif
    step();
    reset = 1'b1;
    step();
    check("t6_hi_addr", imemAddr, 0);
    check("t6_hi_rd", imemRd, 1);
    step(); step(); step();
    check("t6_valid_again", ifidValid, 1);
    check("t6_pc_again", ifidPc, 0);
    check("t6_instr_again", ifidInstr, 32'h1234_5678);
`ifdef FETCH_PERF_EN
    check("t6_count_again", instrCount, 1);
`endif

    // Randomized stall/branch traffic against the expected instruction stream
    expPc    = 32'h0;
    held     = 1'b0;
    brPrev   = 1'b0;
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      if (brPrev) check("rnd_flush", ifidValid, 0);
      if (held) begin
        check("rnd_hold_valid", ifidValid, 1);
        check("rnd_hold_pc", ifidPc, heldPc);
        check("rnd_hold_instr", ifidInstr, heldInstr);
      end
      stall         = ($urandom_range(0, 9) < 3);
      branch_taken  = ($urandom_range(0, 31) == 0);
      branch_target = $urandom;
      held          = ifidValid && stall && !branch_taken;
      heldPc        = ifidPc;
      heldInstr     = ifidInstr;
      if (branch_taken) begin
        expPc = branch_target & ~32'd1;
      end else if (ifidValid && !stall) begin
        check("rnd_pc", ifidPc, expPc);
        check("rnd_instr", ifidInstr, instrAt(expPc));
        expPc = expPc + 32'd2;
        consumed++;
      end
      brPrev = branch_taken;
      step();
    end
    branch_taken = 1'b0;
    stall        = 1'b0;
    check("rnd_progress", (consumed >= 200), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
